// File: rtl/rca4_seq_adder_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encodings and slice width.
package rca4_seq_adder_pkg;

    localparam int SLICE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/rca4_seq_adder_rca4.sv
// 4-bit ripple-carry adder slice, shared by the sequencer over all nibbles.
import rca4_seq_adder_pkg::*;

module rca4 (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W:0] c;

    assign c[0] = ci;

    generate
        for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_fa
            assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign co = c[SLICE_W];

endmodule

// File: rtl/rca4_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one rca4 slice stepped LSB nibble first, carry chained
// through a register, start/done handshake.
import rca4_seq_adder_pkg::*;

module rca4_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [WIDTH-1:0]   s_reg;
    logic               co_reg;
    logic               ovf_reg;

    logic [SLICE_W-1:0] a_nib [NSLICE];
    logic [SLICE_W-1:0] b_nib [NSLICE];
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;
    logic               last_slice;
    logic               accept;

    // Split the captured operands into nibbles so the slice input is a plain mux.
    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[gi*SLICE_W +: SLICE_W];
            assign b_nib[gi] = b_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign slice_a    = a_nib[idx_reg];
    assign slice_b    = b_nib[idx_reg];
    assign last_slice = (idx_reg == IDX_W'(NSLICE - 1));
    assign accept     = start && (state_reg != ST_RUN);

    rca4 u_rca4 (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_reg),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last_slice) state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            s_reg     <= '0;
            co_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= ci;
                idx_reg   <= '0;
            end else if (state_reg == ST_RUN) begin
                s_reg[idx_reg*SLICE_W +: SLICE_W] <= slice_s;
                carry_reg <= slice_co;
                idx_reg   <= idx_reg + IDX_W'(1);
                if (last_slice) begin
                    co_reg  <= slice_co;
                    // Signed overflow only depends on the operand sign bits and the final MSB.
                    ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                               (slice_s[SLICE_W-1] != a_reg[WIDTH-1]);
                end
            end
        end
    end

    assign busy = (state_reg == ST_RUN);
    assign done = (state_reg == ST_DONE);
    assign s    = s_reg;
    assign co   = co_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_rca4_seq_adder.sv
// Directed bench for rca4_seq_adder (WIDTH=16): hand-computed sums, latency, busy,
// back-to-back starts and asynchronous reset.
module tb_rca4_seq_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        co;
    logic        ovf;

    int checks;
    int failures;
    int lat;
    int busy_cnt;
    int seen_done;

    rca4_seq_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op at a negedge, then count edges (E0 inclusive) until done is seen.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic civ,
                          input bit scramble);
        lat      = 0;
        busy_cnt = 0;
        a = av; b = bv; ci = civ; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                lat = n;
                break;
            end
            if (scramble) begin
                a  = 16'($urandom);
                b  = 16'($urandom);
                ci = 1'($urandom);
            end
        end
        $display("op a=%h b=%h ci=%0d -> s=%h co=%0d ovf=%0d lat=%0d busy=%0d",
                 av, bv, civ, s, co, ovf, lat, busy_cnt);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s",    32'(s),    32'd0);
        check("rst_co_ovf", {30'd0, co, ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic carry across nibbles, latency and busy width
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        check("t1_lat",  32'(lat),      32'd5);
        check("t1_busy", 32'(busy_cnt), 32'd4);
        check("t1_s",    32'(s),        32'h0100);
        check("t1_co_ovf", {30'd0, co, ovf}, 32'd0);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_s_hold",     32'(s),    32'h0100);

        // 2: full ripple
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("t2_s",      32'(s), 32'h0000);
        check("t2_co_ovf", {30'd0, co, ovf}, 32'b10);

        // 3: signed overflow, then carry-in
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        check("t3a_s",      32'(s), 32'h8000);
        check("t3a_co_ovf", {30'd0, co, ovf}, 32'b01);
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0);
        check("t3b_s",      32'(s), 32'h5556);
        check("t3b_co_ovf", {30'd0, co, ovf}, 32'b00);

        // 4: start held through RUN is ignored; start in DONE is accepted
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555;
        seen_done = 0;
        for (int n = 0; n < 10 && seen_done == 0; n++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("t4_done_seen", 32'(seen_done), 32'd1);
        check("t4_first_s",   32'(s),         32'h0100);
        @(negedge clk);
        start = 1'b0;
        check("t4_busy_after_done", 32'(busy), 32'd1);
        seen_done = 0;
        for (int n = 0; n < 10 && seen_done == 0; n++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("t4_second_done", 32'(seen_done), 32'd1);
        check("t4_second_s",    32'(s),         32'hFFFF);
        check("t4_second_co_ovf", {30'd0, co, ovf}, 32'b00);
        $display("back-to-back second op s=%h co=%0d ovf=%0d", s, co, ovf);

        // 5: inputs scrambled during RUN
        @(negedge clk);
        run_op(16'h8000, 16'h8000, 1'b1, 1'b1);
        check("t5_lat",    32'(lat), 32'd5);
        check("t5_s",      32'(s),   32'h0001);
        check("t5_co_ovf", {30'd0, co, ovf}, 32'b11);

        // 6: async reset after two slices
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_s",    32'(s),    32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_flags", {29'd0, done, co, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1;
        end
        check("t6_no_spurious", 32'(seen_done), 32'd0);
        run_op(16'h0008, 16'h0008, 1'b0, 1'b0);
        check("t6_lat",    32'(lat), 32'd5);
        check("t6_s",      32'(s),   32'h0010);
        check("t6_co_ovf", {30'd0, co, ovf}, 32'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
